// File: rtl/fifo_frame_packer.sv
// Purpose: drains the sample FIFO into framed bursts (header, 1..FRAME_LEN payload words[, XOR trailer]).
// Latency: a full frame starts one cycle after occupancy reaches FRAME_LEN; a short frame starts after TIMEOUT_CYC idle cycles.
// Backpressure: m_ready low holds the current word; payload pops happen only in the same cycle as a stream transfer.
// Optional feature: define FRAME_CHECKSUM_EN to append an XOR trailer word to every frame.
module fifo_frame_packer #(
   parameter int          DATA_WIDTH      = 32,
   parameter int          FIFO_SIZE_WIDTH = 3,
   parameter int          FRAME_LEN       = 4,
   parameter int          TIMEOUT_CYC     = 64,
   parameter logic [15:0] SYNC_WORD       = 16'hA55A
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     en,
   input  logic                     fifo_rdy,
   input  logic [DATA_WIDTH-1:0]    fifo_data,
   input  logic [FIFO_SIZE_WIDTH:0] fifo_size,
   output logic                     fifo_rd,
   output logic [DATA_WIDTH-1:0]    m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic                     m_last,
   output logic [7:0]               seq_num,
   output logic                     busy
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

`ifdef FRAME_CHECKSUM_EN
   typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_TRAILER} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD} state_t;
`endif

   state_t          state_q, state_d;
   logic [7:0]      seq_q, seq_d;
   logic [7:0]      len_q, len_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [TW-1:0]   timer_q, timer_d;
`ifdef FRAME_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] xor_q, xor_d;
`endif

   logic [31:0]           size_ext;
   logic                  size_nz;
   logic                  size_full;
   logic                  last_pay;
   logic [DATA_WIDTH-1:0] hdr_word;

   assign size_ext  = 32'(fifo_size);
   assign size_nz   = (size_ext != 32'd0);
   assign size_full = (size_ext >= 32'(FRAME_LEN));
   assign hdr_word  = DATA_WIDTH'({SYNC_WORD, seq_q, len_q});
   assign seq_num   = seq_q;
   assign busy      = (state_q != S_IDLE);

   // Next-state, stream outputs and FIFO pop; outputs are decoded from the current state so reset clears them at once
   always_comb begin
      state_d  = state_q;
      seq_d    = seq_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      timer_d  = timer_q;
`ifdef FRAME_CHECKSUM_EN
      xor_d    = xor_q;
`endif
      m_valid  = 1'b0;
      m_last   = 1'b0;
      m_data   = '0;
      fifo_rd  = 1'b0;
      last_pay = (cnt_q == (len_q - 8'd1));
      case (state_q)
         S_IDLE: begin
            // Timer saturates so a long en=0 period cannot wrap it back below the threshold
            if (size_nz && !size_full)
               timer_d = (timer_q == TMAX) ? timer_q : timer_q + TW'(1);
            else
               timer_d = '0;
            if (en && (size_full || (size_nz && timer_q == TMAX))) begin
               state_d = S_HEADER;
               len_d   = size_full ? 8'(FRAME_LEN) : 8'(fifo_size);
               timer_d = '0;
`ifdef FRAME_CHECKSUM_EN
               xor_d   = '0;
`endif
            end
         end
         S_HEADER: begin
            m_valid = 1'b1;
            m_data  = hdr_word;
            if (m_ready) begin
               state_d = S_PAYLOAD;
               cnt_d   = 8'd0;
`ifdef FRAME_CHECKSUM_EN
               xor_d   = xor_q ^ hdr_word;
`endif
            end
         end
         S_PAYLOAD: begin
            // Head word is forwarded straight through; a pop only ever accompanies a transfer
            m_valid = fifo_rdy;
            m_data  = fifo_data;
            fifo_rd = m_ready & fifo_rdy;
`ifndef FRAME_CHECKSUM_EN
            m_last  = last_pay;
`endif
            if (fifo_rd) begin
               cnt_d = cnt_q + 8'd1;
`ifdef FRAME_CHECKSUM_EN
               xor_d = xor_q ^ fifo_data;
               if (last_pay) state_d = S_TRAILER;
`else
               if (last_pay) begin
                  state_d = S_IDLE;
                  seq_d   = seq_q + 8'd1;
               end
`endif
            end
         end
`ifdef FRAME_CHECKSUM_EN
         S_TRAILER: begin
            m_valid = 1'b1;
            m_last  = 1'b1;
            m_data  = xor_q;
            if (m_ready) begin
               state_d = S_IDLE;
               seq_d   = seq_q + 8'd1;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset abandons any frame in flight
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         seq_q   <= 8'd0;
         len_q   <= 8'd0;
         cnt_q   <= 8'd0;
         timer_q <= '0;
`ifdef FRAME_CHECKSUM_EN
         xor_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         seq_q   <= seq_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         timer_q <= timer_d;
`ifdef FRAME_CHECKSUM_EN
         xor_q   <= xor_d;
`endif
      end
   end

endmodule

// File: tb/tb_fifo_frame_packer.sv
// Bench for fifo_frame_packer: behavioural FIFO, transfer monitor, frame-level reference model.
// Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
// Frames are predicted from queued words and compared word by word with the observed stream.
module tb_fifo_frame_packer;

   localparam int FL = 4;

   logic        clk = 1'b0;
   logic        rstn, en, m_ready;
   logic        fifo_rdy, fifo_rd, m_valid, m_last, busy;
   logic [31:0] fifo_data, m_data;
   logic [3:0]  fifo_size;
   logic [7:0]  seq_num;

   always #5 clk = ~clk;

   fifo_frame_packer dut (
      .clk(clk), .rstn(rstn), .en(en),
      .fifo_rdy(fifo_rdy), .fifo_data(fifo_data), .fifo_size(fifo_size), .fifo_rd(fifo_rd),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .seq_num(seq_num), .busy(busy)
   );

   // Behavioural upstream FIFO: bench pushes, DUT pops
   logic [31:0] mem [0:2047];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign fifo_size = 4'(wr_ptr - rd_ptr);
   assign fifo_rdy  = (wr_ptr != rd_ptr);
   assign fifo_data = mem[rd_ptr % 2048];

   always @(posedge clk) if (fifo_rd) rd_ptr <= rd_ptr + 1;

   // Transfer monitor and protocol watchers
   logic [32:0] obs_mem [0:4095];
   int obs_wr = 0;
   int rd_bad = 0, rd_empty = 0, stall_bad = 0, gap_bad = 0;
   logic        prev_stall = 1'b0, prev_lastx = 1'b0, prev_l = 1'b0;
   logic [31:0] prev_d = '0;

   always @(negedge clk) begin
      if (!rstn) begin
         prev_stall = 1'b0;
         prev_lastx = 1'b0;
      end else begin
         if (m_valid && m_ready) begin
            obs_mem[obs_wr % 4096] = {m_last, m_data};
            obs_wr = obs_wr + 1;
         end
         if (fifo_rd && !(m_valid && m_ready)) rd_bad++;
         if (fifo_rd && !fifo_rdy) rd_empty++;
         if (prev_stall && (!m_valid || m_data != prev_d || m_last != prev_l)) stall_bad++;
         if (prev_lastx && m_valid) gap_bad++;
         prev_stall = m_valid && !m_ready;
         prev_d     = m_data;
         prev_l     = m_last;
         prev_lastx = m_valid && m_ready && m_last;
      end
   end

   // Reference model state
   logic [31:0] mdl_q [$];
   logic [32:0] exp_q [$];
   logic [7:0]  mdl_seq = 8'd0;
   int obs_rd = 0;
   int tests = 0;
   int fails = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [31:0] w);
      mem[wr_ptr % 2048] = w;
      wr_ptr = wr_ptr + 1;
      mdl_q.push_back(w);
   endtask

   // One frame from the front of the queued words: len = min(queued, FRAME_LEN)
   task automatic model_frame();
      int len;
      logic [31:0] x, w;
      len = (mdl_q.size() < FL) ? mdl_q.size() : FL;
      x = {16'hA55A, mdl_seq, 8'(len)};
      exp_q.push_back({1'b0, x});
      for (int i = 0; i < len; i++) begin
         w = mdl_q.pop_front();
         x = x ^ w;
`ifdef FRAME_CHECKSUM_EN
         exp_q.push_back({1'b0, w});
`else
         exp_q.push_back({(i == len - 1), w});
`endif
      end
`ifdef FRAME_CHECKSUM_EN
      exp_q.push_back({1'b1, x});
`endif
      mdl_seq = mdl_seq + 8'd1;
   endtask

   // Wait for all predicted words, optionally with random m_ready, then compare in order
   task automatic drain(input string tag, input bit rnd, input int budget);
      int n;
      logic [32:0] e;
      n = 0;
      while ((obs_wr - obs_rd) < exp_q.size() && n < budget) begin
         m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         n++;
      end
      m_ready = 1'b1;
      chk({tag, "_count"}, 64'(obs_wr - obs_rd), 64'(exp_q.size()));
      while (exp_q.size() > 0 && obs_rd < obs_wr) begin
         e = exp_q.pop_front();
         chk(tag, 64'(obs_mem[obs_rd % 4096]), 64'(e));
         obs_rd++;
      end
      exp_q.delete();
   endtask

   initial begin
      int r0, k, busy_seen, o0, n, popped;
      rstn = 1'b1; en = 1'b0; m_ready = 1'b1;
      #3 rstn = 1'b0;
      tick(); tick();
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_m_last",  64'(m_last),  64'd0);
      chk("rst_fifo_rd", 64'(fifo_rd), 64'd0);
      chk("rst_m_data",  64'(m_data),  64'd0);
      chk("rst_seq_num", 64'(seq_num), 64'd0);
      chk("rst_busy",    64'(busy),    64'd0);
      rstn = 1'b1;
      tick();

      // Full frame 1..4
      en = 1'b1;
      r0 = rd_ptr;
      for (int i = 1; i <= 4; i++) push(32'(i));
      model_frame();
      drain("full", 1'b0, 100);
      chk("full_pops", 64'(rd_ptr - r0), 64'd4);
      chk("full_seq", 64'(seq_num), 64'd1);

      // Single word released by the idle timeout
      push(32'd9);
      k = 0;
      while (!m_valid && k < 200) begin tick(); k++; end
      chk("timeout_lat", 64'(k), 64'd64);
      model_frame();
      drain("timeout", 1'b0, 100);
      chk("timeout_seq", 64'(seq_num), 64'd2);

      // Random words and lengths under random backpressure
      for (int f = 0; f < 6; f++) begin
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) push($urandom);
         while (mdl_q.size() > 0) model_frame();
         drain("rand", 1'b1, 800);
      end
      chk("rand_seq", 64'(seq_num), 64'(mdl_seq));

      // en low: queued words do not start a frame
      en = 1'b0;
      o0 = obs_wr;
      for (int i = 0; i < 4; i++) push($urandom);
      busy_seen = 0;
      for (int i = 0; i < 30; i++) begin tick(); if (busy) busy_seen++; end
      chk("en0_busy", 64'(busy_seen), 64'd0);
      chk("en0_noout", 64'(obs_wr - o0), 64'd0);
      // Drop en in PAYLOAD: frame still completes
      en = 1'b1;
      model_frame();
      r0 = rd_ptr;
      k = 0;
      while (rd_ptr == r0 && k < 50) begin tick(); k++; end
      en = 1'b0;
      drain("en_drop", 1'b0, 100);
      o0 = obs_wr;
      for (int i = 0; i < 4; i++) push($urandom);
      busy_seen = 0;
      for (int i = 0; i < 100; i++) begin tick(); if (busy) busy_seen++; end
      chk("en_drop_idle", 64'(busy_seen), 64'd0);
      chk("en_drop_noout", 64'(obs_wr - o0), 64'd0);
      en = 1'b1;
      model_frame();
      drain("en_resume", 1'b0, 100);

      // Sequence number wrap across 256 frames
      for (int f = 0; f < 256; f++) begin
         for (int i = 0; i < 4; i++) push($urandom);
         model_frame();
         drain("wrap", 1'b0, 100);
      end
      chk("wrap_seq", 64'(seq_num), 64'(mdl_seq));

      // Asynchronous reset in the middle of a payload
      r0 = rd_ptr;
      for (int i = 0; i < 4; i++) push($urandom);
      k = 0;
      while ((rd_ptr - r0) < 2 && k < 50) begin tick(); k++; end
      #2 rstn = 1'b0;
      #1;
      chk("arst_m_valid", 64'(m_valid), 64'd0);
      chk("arst_fifo_rd", 64'(fifo_rd), 64'd0);
      chk("arst_m_last",  64'(m_last),  64'd0);
      chk("arst_m_data",  64'(m_data),  64'd0);
      chk("arst_busy",    64'(busy),    64'd0);
      chk("arst_seq",     64'(seq_num), 64'd0);
      popped = rd_ptr - r0;
      for (int i = 0; i < popped; i++) void'(mdl_q.pop_front());
      obs_rd = obs_wr;
      mdl_seq = 8'd0;
      tick(); tick();
      rstn = 1'b1;
      model_frame();
      drain("post_rst", 1'b0, 200);
      chk("post_rst_seq", 64'(seq_num), 64'd1);

      // Protocol watchers and pop accounting
      chk("all_popped", 64'(wr_ptr - rd_ptr), 64'd0);
      chk("rd_without_xfer", 64'(rd_bad), 64'd0);
      chk("rd_when_empty", 64'(rd_empty), 64'd0);
      chk("stall_unstable", 64'(stall_bad), 64'd0);
      chk("no_idle_gap", 64'(gap_bad), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
